// File: rtl/commit_unit.sv
// In-order N-wide retirement stage: pops the longest committable ROB prefix, writes the ARF,
// releases one store per cycle and raises a precise flush. Optional counters: COMMIT_PERF_CNT_EN.
module commit_unit #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    COMMIT_WIDTH = 2,
   parameter int                    TAG_W        = 4,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VEC     = 32'h0000_0100,
   localparam int                   CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [COMMIT_WIDTH-1:0]            rob_head_valid_i,
   input  logic [COMMIT_WIDTH-1:0]            rob_head_done_i,
   input  logic [COMMIT_WIDTH-1:0]            rob_head_exc_i,
   input  logic [COMMIT_WIDTH-1:0]            rob_head_wen_i,
   input  logic [COMMIT_WIDTH-1:0]            rob_head_store_i,
   input  logic [5*COMMIT_WIDTH-1:0]          rob_head_rd_i,
   input  logic [DATA_WIDTH*COMMIT_WIDTH-1:0] rob_head_data_i,
   input  logic [TAG_W*COMMIT_WIDTH-1:0]      rob_head_tag_i,
   input  logic [ADDR_WIDTH*COMMIT_WIDTH-1:0] rob_head_pc_i,
   input  logic                               rob_empty_i,
   output logic [CNT_W-1:0]                   rob_pop_cnt_o,
   output logic                               sb_commit_valid_o,
   input  logic                               sb_commit_ready_i,
   output logic [COMMIT_WIDTH-1:0]            arf_we_o,
   output logic [5*COMMIT_WIDTH-1:0]          arf_waddr_o,
   output logic [DATA_WIDTH*COMMIT_WIDTH-1:0] arf_wdata_o,
   output logic [TAG_W*COMMIT_WIDTH-1:0]      rt_clr_tag_o,
   output logic                               flush_o,
   output logic [ADDR_WIDTH-1:0]              redirect_pc_o,
   output logic [ADDR_WIDTH-1:0]              epc_o,
`ifdef COMMIT_PERF_CNT_EN
   output logic [63:0]                        instret_o,
   output logic [31:0]                        stall_cyc_o,
`endif
   output logic [1:0]                         dbg_state_o   // 0=RUN 1=FLUSH 2=DRAIN
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                            r_state;
   logic [COMMIT_WIDTH-1:0]           r_arf_we;
   logic [5*COMMIT_WIDTH-1:0]         r_arf_waddr;
   logic [DATA_WIDTH*COMMIT_WIDTH-1:0] r_arf_wdata;
   logic [TAG_W*COMMIT_WIDTH-1:0]     r_rt_clr_tag;
   logic                              r_flush;
   logic [ADDR_WIDTH-1:0]             r_redirect_pc;
   logic [ADDR_WIDTH-1:0]             r_epc;

   logic [COMMIT_WIDTH-1:0]           w_commit;
   logic [COMMIT_WIDTH-1:0]           w_we;
   logic [CNT_W-1:0]                  w_pop;
   logic                              w_stop;
   logic                              w_store_seen;
   logic                              w_sb_valid;
   logic                              w_exc_hit;
   logic [ADDR_WIDTH-1:0]             w_exc_pc;

   // Prefix scan: the first slot that cannot retire ends the group for this cycle.
   always_comb begin
      w_commit     = '0;
      w_stop       = 1'b0;
      w_store_seen = 1'b0;
      w_sb_valid   = 1'b0;
      w_exc_hit    = 1'b0;
      w_exc_pc     = '0;
      if (rst_n && (r_state == ST_RUN)) begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (!w_stop) begin
               if (!(rob_head_valid_i[k] && rob_head_done_i[k])) begin
                  w_stop = 1'b1;
               end else if (rob_head_exc_i[k]) begin
                  w_exc_hit = 1'b1;
                  w_exc_pc  = rob_head_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                  w_stop    = 1'b1;
               end else if (rob_head_store_i[k]) begin
                  if (w_store_seen) begin
                     w_stop = 1'b1;
                  end else begin
                     w_store_seen = 1'b1;
                     w_sb_valid   = 1'b1;
                     if (sb_commit_ready_i) w_commit[k] = 1'b1;
                     else                   w_stop      = 1'b1;
                  end
               end else begin
                  w_commit[k] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      w_pop = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         w_pop = w_pop + CNT_W'(w_commit[k]);
      end
   end

   // A younger committing write to the same rd supersedes the older one within a group.
   always_comb begin
      w_we = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         w_we[k] = w_commit[k] & rob_head_wen_i[k] & (rob_head_rd_i[k*5 +: 5] != 5'd0);
         for (int j = k + 1; j < COMMIT_WIDTH; j++) begin
            if (w_commit[j] && rob_head_wen_i[j] &&
                (rob_head_rd_i[j*5 +: 5] == rob_head_rd_i[k*5 +: 5])) begin
               w_we[k] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_arf_we      <= '0;
         r_arf_waddr   <= '0;
         r_arf_wdata   <= '0;
         r_rt_clr_tag  <= '0;
         r_flush       <= 1'b0;
         r_redirect_pc <= '0;
         r_epc         <= '0;
      end else begin
         r_flush       <= 1'b0;
         r_redirect_pc <= '0;
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            r_arf_we[k]                             <= w_we[k];
            r_arf_waddr[k*5 +: 5]                   <= w_we[k] ? rob_head_rd_i[k*5 +: 5] : 5'd0;
            r_arf_wdata[k*DATA_WIDTH +: DATA_WIDTH] <= w_we[k] ?
               rob_head_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
            r_rt_clr_tag[k*TAG_W +: TAG_W]          <= w_we[k] ?
               rob_head_tag_i[k*TAG_W +: TAG_W] : '0;
         end
         case (r_state)
            ST_RUN: begin
               if (w_exc_hit) begin
                  r_state       <= ST_FLUSH;
                  r_flush       <= 1'b1;
                  r_redirect_pc <= TRAP_VEC;
                  r_epc         <= w_exc_pc;
               end
            end
            ST_FLUSH: r_state <= ST_DRAIN;
            ST_DRAIN: if (rob_empty_i) r_state <= ST_RUN;
            default:  r_state <= ST_RUN;
         endcase
      end
   end

`ifdef COMMIT_PERF_CNT_EN
   logic [63:0] r_instret;
   logic [31:0] r_stall_cyc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instret   <= '0;
         r_stall_cyc <= '0;
      end else begin
         r_instret <= r_instret + 64'(w_pop);
         if ((r_state == ST_RUN) && !rob_empty_i && (w_pop == '0) && (r_stall_cyc != '1)) begin
            r_stall_cyc <= r_stall_cyc + 32'd1;
         end
      end
   end

   assign instret_o   = r_instret;
   assign stall_cyc_o = r_stall_cyc;
`endif

   assign rob_pop_cnt_o     = w_pop;
   assign sb_commit_valid_o = w_sb_valid;
   assign arf_we_o          = r_arf_we;
   assign arf_waddr_o       = r_arf_waddr;
   assign arf_wdata_o       = r_arf_wdata;
   assign rt_clr_tag_o      = r_rt_clr_tag;
   assign flush_o           = r_flush;
   assign redirect_pc_o     = r_redirect_pc;
   assign epc_o             = r_epc;
   assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios plus randomized traffic against
// a behavioural model of the retirement rules.
module tb_commit_unit;
   localparam int CW = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TW = 4;
   localparam logic [AW-1:0] TRAP = 32'h0000_0100;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CW-1:0]   valid, done, exc, wen, store;
   logic [5*CW-1:0] rd;
   logic [DW*CW-1:0] data;
   logic [TW*CW-1:0] tag;
   logic [AW*CW-1:0] pc;
   logic            rob_empty, sb_ready;
   logic [1:0]      pop;
   logic            sbv;
   logic [CW-1:0]   we;
   logic [5*CW-1:0] waddr;
   logic [DW*CW-1:0] wdata;
   logic [TW*CW-1:0] clr_tag;
   logic            flush;
   logic [AW-1:0]   redir, epc;
   logic [1:0]      state;
`ifdef COMMIT_PERF_CNT_EN
   logic [63:0]     instret;
   logic [31:0]     stall_cyc;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   commit_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COMMIT_WIDTH(CW), .TAG_W(TW),
                 .TRAP_VEC(TRAP)) dut (
      .clk(clk), .rst_n(rst_n),
      .rob_head_valid_i(valid), .rob_head_done_i(done), .rob_head_exc_i(exc),
      .rob_head_wen_i(wen), .rob_head_store_i(store), .rob_head_rd_i(rd),
      .rob_head_data_i(data), .rob_head_tag_i(tag), .rob_head_pc_i(pc),
      .rob_empty_i(rob_empty), .rob_pop_cnt_o(pop),
      .sb_commit_valid_o(sbv), .sb_commit_ready_i(sb_ready),
      .arf_we_o(we), .arf_waddr_o(waddr), .arf_wdata_o(wdata), .rt_clr_tag_o(clr_tag),
      .flush_o(flush), .redirect_pc_o(redir), .epc_o(epc),
`ifdef COMMIT_PERF_CNT_EN
      .instret_o(instret), .stall_cyc_o(stall_cyc),
`endif
      .dbg_state_o(state)
   );

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_slots();
      valid = '0; done = '0; exc = '0; wen = '0; store = '0;
      rd = '0; data = '0; tag = '0; pc = '0;
      rob_empty = 1'b0; sb_ready = 1'b1;
   endtask

   task automatic set_slot(input int k, input logic vl, input logic dn, input logic ex,
                           input logic wn, input logic st, input logic [4:0] r,
                           input logic [DW-1:0] dat, input logic [TW-1:0] tg,
                           input logic [AW-1:0] p);
      valid[k] = vl; done[k] = dn; exc[k] = ex; wen[k] = wn; store[k] = st;
      rd[k*5 +: 5] = r; data[k*DW +: DW] = dat; tag[k*TW +: TW] = tg; pc[k*AW +: AW] = p;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      clear_slots();
      set_slot(0, 1, 1, 0, 1, 0, 5'd4, 32'h1234, 4'h3, 32'h10);
      #1;
      n_vec++;
      if (pop !== 2'd0 || sbv !== 1'b0) begin
         n_err++; $display("FAIL reset_comb: pop=%0d sbv=%0b expected 0 0", pop, sbv);
      end
      step();
      n_vec++;
      if ({we, waddr, wdata, clr_tag, flush, redir, epc, state} !== '0) begin
         n_err++;
         $display("FAIL reset_regs: we=%b waddr=%h wdata=%h tag=%h flush=%b redir=%h epc=%h st=%0d expected all 0",
                  we, waddr, wdata, clr_tag, flush, redir, epc, state);
      end
      rst_n = 1'b1;
      clear_slots();
   endtask

   task automatic test_two_commit();
      clear_slots();
      set_slot(0, 1, 1, 0, 1, 0, 5'd5, 32'hA, 4'h1, 32'h20);
      set_slot(1, 1, 1, 0, 1, 0, 5'd6, 32'hB, 4'h2, 32'h24);
      #1;
      n_vec++;
      if (pop !== 2'd2) begin n_err++; $display("FAIL two_pop: got %0d expected 2", pop); end
      step();
      n_vec++;
      if (we !== 2'b11 || waddr !== {5'd6, 5'd5} || wdata !== {32'hB, 32'hA} ||
          clr_tag !== {4'h2, 4'h1}) begin
         n_err++;
         $display("FAIL two_arf: we=%b waddr=%h wdata=%h tag=%h expected 11 %h %h %h",
                  we, waddr, wdata, clr_tag, {5'd6, 5'd5}, {32'hB, 32'hA}, {4'h2, 4'h1});
      end
   endtask

   task automatic test_partial();
      clear_slots();
      set_slot(0, 1, 1, 0, 1, 0, 5'd3, 32'h33, 4'h4, 32'h30);
      set_slot(1, 1, 0, 0, 1, 0, 5'd4, 32'h44, 4'h5, 32'h34);
      #1;
      n_vec++;
      if (pop !== 2'd1) begin n_err++; $display("FAIL partial_pop: got %0d expected 1", pop); end
      step();
      n_vec++;
      if (we !== 2'b01 || waddr[4:0] !== 5'd3 || wdata[31:0] !== 32'h33) begin
         n_err++; $display("FAIL partial_arf: we=%b waddr0=%0d wdata0=%h expected 01 3 33",
                           we, waddr[4:0], wdata[31:0]);
      end
      done[0] = 1'b0; done[1] = 1'b1;
      #1;
      n_vec++;
      if (pop !== 2'd0) begin n_err++; $display("FAIL notdone_pop: got %0d expected 0", pop); end
      step();
      n_vec++;
      if (we !== 2'b00) begin n_err++; $display("FAIL notdone_arf: we=%b expected 00", we); end
   endtask

   task automatic test_waw();
      clear_slots();
      set_slot(0, 1, 1, 0, 1, 0, 5'd7, 32'h1, 4'h6, 32'h50);
      set_slot(1, 1, 1, 0, 1, 0, 5'd7, 32'h2, 4'h7, 32'h54);
      #1;
      n_vec++;
      if (pop !== 2'd2) begin n_err++; $display("FAIL waw_pop: got %0d expected 2", pop); end
      step();
      n_vec++;
      if (we !== 2'b10 || waddr[9:5] !== 5'd7 || wdata[63:32] !== 32'h2 || clr_tag[7:4] !== 4'h7) begin
         n_err++; $display("FAIL waw_arf: we=%b waddr1=%0d wdata1=%h tag1=%h expected 10 7 2 7",
                           we, waddr[9:5], wdata[63:32], clr_tag[7:4]);
      end
   endtask

   task automatic test_rd_zero();
      clear_slots();
      set_slot(0, 1, 1, 0, 1, 0, 5'd0, 32'hDEAD, 4'h8, 32'h60);
      #1;
      n_vec++;
      if (pop !== 2'd1) begin n_err++; $display("FAIL x0_pop: got %0d expected 1", pop); end
      step();
      n_vec++;
      if (we !== 2'b00) begin n_err++; $display("FAIL x0_arf: we=%b expected 00", we); end
   endtask

   task automatic test_store_stall();
      clear_slots();
      sb_ready = 1'b0;
      set_slot(0, 1, 1, 0, 0, 1, 5'd0, 32'h0, 4'h9, 32'h70);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (sbv !== 1'b1 || pop !== 2'd0) begin
            n_err++; $display("FAIL store_stall c%0d: sbv=%b pop=%0d expected 1 0", c, sbv, pop);
         end
         step();
      end
      sb_ready = 1'b1;
      #1;
      n_vec++;
      if (sbv !== 1'b1 || pop !== 2'd1) begin
         n_err++; $display("FAIL store_go: sbv=%b pop=%0d expected 1 1", sbv, pop);
      end
      step();
      set_slot(1, 1, 1, 0, 0, 1, 5'd0, 32'h0, 4'hA, 32'h74);
      #1;
      n_vec++;
      if (sbv !== 1'b1 || pop !== 2'd1) begin
         n_err++; $display("FAIL two_stores: sbv=%b pop=%0d expected 1 1", sbv, pop);
      end
      step();
   endtask

   task automatic test_exception_drain();
      clear_slots();
      set_slot(0, 1, 1, 0, 1, 0, 5'd3, 32'h5, 4'h1, 32'h3C);
      set_slot(1, 1, 1, 1, 1, 0, 5'd4, 32'h6, 4'h2, 32'h40);
      #1;
      n_vec++;
      if (pop !== 2'd1) begin n_err++; $display("FAIL exc_pop: got %0d expected 1", pop); end
      step();
      n_vec++;
      if (flush !== 1'b1 || redir !== TRAP || epc !== 32'h40 || state !== 2'd1 || we !== 2'b01) begin
         n_err++; $display("FAIL exc_flush: flush=%b redir=%h epc=%h st=%0d we=%b expected 1 100 40 1 01",
                           flush, redir, epc, state, we);
      end
      set_slot(1, 1, 1, 0, 1, 0, 5'd4, 32'h6, 4'h2, 32'h40);
      #1;
      n_vec++;
      if (pop !== 2'd0 || sbv !== 1'b0) begin
         n_err++; $display("FAIL flush_quiet: pop=%0d sbv=%b expected 0 0", pop, sbv);
      end
      step();
      for (int c = 0; c < 2; c++) begin
         n_vec++;
         if (state !== 2'd2 || flush !== 1'b0 || redir !== '0 || epc !== 32'h40 || pop !== 2'd0) begin
            n_err++; $display("FAIL drain c%0d: st=%0d flush=%b redir=%h epc=%h pop=%0d expected 2 0 0 40 0",
                              c, state, flush, redir, epc, pop);
         end
         step();
      end
      rob_empty = 1'b1;
      clear_slots();
      rob_empty = 1'b1;
      step();
      n_vec++;
      if (state !== 2'd0 || epc !== 32'h40) begin
         n_err++; $display("FAIL drain_exit: st=%0d epc=%h expected 0 40", state, epc);
      end
      rob_empty = 1'b0;
   endtask

   task automatic test_reset_in_drain();
      clear_slots();
      set_slot(0, 1, 1, 1, 0, 0, 5'd0, 32'h0, 4'h0, 32'h80);
      step();
      clear_slots();
      step();
      n_vec++;
      if (state !== 2'd2) begin n_err++; $display("FAIL to_drain: st=%0d expected 2", state); end
      set_slot(0, 1, 1, 0, 1, 0, 5'd9, 32'h99, 4'h3, 32'h84);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (pop !== 2'd0 || sbv !== 1'b0) begin
         n_err++; $display("FAIL rst_drain_comb: pop=%0d sbv=%b expected 0 0", pop, sbv);
      end
      step();
      n_vec++;
      if ({we, waddr, wdata, clr_tag, flush, redir, epc, state} !== '0) begin
         n_err++; $display("FAIL rst_drain_regs: we=%b flush=%b epc=%h st=%0d expected all 0",
                           we, flush, epc, state);
      end
      rst_n = 1'b1;
      clear_slots();
   endtask

   task automatic test_random();
      int              m_state;
      int              e_pop;
      bit              e_sbv, exc_hit, stores;
      logic [AW-1:0]   exc_pc, e_epc, e_redir;
      logic [CW-1:0]   e_we;
      logic [5*CW-1:0] e_waddr;
      logic [DW*CW-1:0] e_wdata;
      logic [TW*CW-1:0] e_tag;
      logic            e_flush;
      int              last[int];
`ifdef COMMIT_PERF_CNT_EN
      logic [63:0]     m_instret;
      logic [31:0]     m_stall;
      m_instret = '0; m_stall = '0;
`endif
      m_state = 0; e_epc = '0;
      for (int i = 0; i < 400; i++) begin
         rst_n     = (i == 0 || $urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
         rob_empty = ($urandom_range(0, 99) < ((m_state == 2) ? 40 : 10));
         sb_ready  = ($urandom_range(0, 99) < 70);
         for (int k = 0; k < CW; k++) begin
            set_slot(k, !rob_empty && ($urandom_range(0, 99) < 90), $urandom_range(0, 99) < 75,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 25, 5'($urandom_range(0, 7)), $urandom,
                     4'($urandom_range(0, 15)), {$urandom_range(0, 255), 2'b00});
         end
         // Expected retirement group: longest prefix of ready slots, one store at most.
         e_pop = 0; e_sbv = 0; exc_hit = 0; exc_pc = '0; stores = 0;
         if (rst_n && m_state == 0) begin
            for (int k = 0; k < CW; k++) begin
               if (!(valid[k] && done[k] && !exc[k])) begin
                  if (valid[k] && done[k]) begin exc_hit = 1; exc_pc = pc[k*AW +: AW]; end
                  break;
               end
               if (store[k]) begin
                  if (stores) break;
                  stores = 1; e_sbv = 1;
                  if (!sb_ready) break;
               end
               e_pop++;
            end
         end
         #1;
         n_vec++;
         if (pop !== 2'(e_pop) || sbv !== e_sbv) begin
            n_err++; $display("FAIL rnd%0d_comb: pop=%0d sbv=%b expected %0d %b", i, pop, sbv, e_pop, e_sbv);
         end
         last.delete();
         for (int k = 0; k < e_pop; k++)
            if (wen[k] && rd[k*5 +: 5] != 5'd0) last[int'(rd[k*5 +: 5])] = k;
         e_we = '0; e_waddr = '0; e_wdata = '0; e_tag = '0; e_flush = 0; e_redir = '0;
         for (int k = 0; k < e_pop; k++) begin
            if (wen[k] && rd[k*5 +: 5] != 5'd0 && last[int'(rd[k*5 +: 5])] == k) begin
               e_we[k] = 1'b1;
               e_waddr[k*5 +: 5]   = rd[k*5 +: 5];
               e_wdata[k*DW +: DW] = data[k*DW +: DW];
               e_tag[k*TW +: TW]   = tag[k*TW +: TW];
            end
         end
`ifdef COMMIT_PERF_CNT_EN
         if (!rst_n) begin m_instret = '0; m_stall = '0; end
         else begin
            m_instret = m_instret + 64'(e_pop);
            if (m_state == 0 && !rob_empty && e_pop == 0 && m_stall != '1) m_stall = m_stall + 1;
         end
`endif
         if (!rst_n) begin
            m_state = 0; e_epc = '0; e_we = '0; e_waddr = '0; e_wdata = '0; e_tag = '0;
         end else if (m_state == 0) begin
            if (exc_hit) begin m_state = 1; e_flush = 1; e_redir = TRAP; e_epc = exc_pc; end
         end else if (m_state == 1) begin
            m_state = 2;
         end else if (rob_empty) begin
            m_state = 0;
         end
         step();
         n_vec++;
         if (we !== e_we || waddr !== e_waddr || wdata !== e_wdata || clr_tag !== e_tag) begin
            n_err++; $display("FAIL rnd%0d_arf: we=%b waddr=%h wdata=%h tag=%h expected %b %h %h %h",
                              i, we, waddr, wdata, clr_tag, e_we, e_waddr, e_wdata, e_tag);
         end
         n_vec++;
         if (flush !== e_flush || redir !== e_redir || epc !== e_epc || state !== 2'(m_state)) begin
            n_err++; $display("FAIL rnd%0d_ctl: flush=%b redir=%h epc=%h st=%0d expected %b %h %h %0d",
                              i, flush, redir, epc, state, e_flush, e_redir, e_epc, m_state);
         end
`ifdef COMMIT_PERF_CNT_EN
         n_vec++;
         if (instret !== m_instret || stall_cyc !== m_stall) begin
            n_err++; $display("FAIL rnd%0d_perf: instret=%0d stall=%0d expected %0d %0d",
                              i, instret, stall_cyc, m_instret, m_stall);
         end
`endif
      end
      rst_n = 1'b1;
      clear_slots();
   endtask

   initial begin
      clear_slots();
      rst_n = 1'b0;
      test_reset();
      test_two_commit();
      test_partial();
      test_waw();
      test_rd_zero();
      test_store_stall();
      test_exception_drain();
      test_reset_in_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, expected completion");
      $fatal(1, "timeout");
   end

endmodule
